// File: rtl/pipe_skid_stage_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the two-entry skid stage:
//   state_e         occupancy state of the stage (value == entries held)
//   PC_RST_DEFAULT  PC presented on the outputs when no entry is valid
//   EXC_*           bit positions inside the exception flag vector
//   occ_of()        maps a state to its 2-bit occupancy count
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [31:0] PC_RST_DEFAULT = 32'hbfc00000;

    localparam int unsigned EXC_SYSCALL  = 0;
    localparam int unsigned EXC_BREAK    = 1;
    localparam int unsigned EXC_RESERVED = 2;
    localparam int unsigned EXC_OVERFLOW = 3;
    localparam int unsigned EXC_ADES     = 4;
    localparam int unsigned EXC_ADEL     = 5;
    localparam int unsigned EXC_ADEF     = 6;
    localparam int unsigned EXC_SLOT     = 7;

    // The enum values are chosen so that the encoding is the entry count.
    function automatic logic [1:0] occ_of(state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// ----------------------------------------------------------------------------
// pipe_skid_stage_if
// Handshake bundle around the skid stage.
//   upstream   : in_valid, in_ready, in_data, in_pc, in_exc
//   downstream : out_valid, out_ready, out_data, out_pc, out_exc, out_exc_any
//   control    : flush (discard everything), occupancy (0..2 entries held)
// Modports:
//   master : the environment (drives inputs, consumes outputs)
//   slave  : the stage itself
// ----------------------------------------------------------------------------
interface pipe_skid_stage_if #(
    parameter int DATA_W = 104,
    parameter int EXC_W  = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [31:0]       in_pc;
    logic [EXC_W-1:0]  in_exc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       out_pc;
    logic [EXC_W-1:0]  out_exc;
    logic              out_exc_any;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, in_data, in_pc, in_exc, out_ready,
        input  in_ready, out_valid, out_data, out_pc, out_exc, out_exc_any, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, in_pc, in_exc, out_ready,
        output in_ready, out_valid, out_data, out_pc, out_exc, out_exc_any, occupancy
    );

endinterface

// File: rtl/pipe_skid_stage_entry.sv
// ----------------------------------------------------------------------------
// pipe_entry
// One payload slot (data, pc, exception flags) with load enable. Reset clears
// the slot asynchronously to the bubble values (0 / PC_RST / 0).
//   clk, rst_n          clock, asynchronous active-low clear
//   ld_i                capture data_i/pc_i/exc_i on the rising edge
//   data_o/pc_o/exc_o   stored payload
// ----------------------------------------------------------------------------
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int          DATA_W = 104,
    parameter int          EXC_W  = 8,
    parameter logic [31:0] PC_RST = PC_RST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [31:0]       pc_i,
    input  logic [EXC_W-1:0]  exc_i,
    output logic [DATA_W-1:0] data_o,
    output logic [31:0]       pc_o,
    output logic [EXC_W-1:0]  exc_o
);

    logic [DATA_W-1:0] data_q;
    logic [31:0]       pc_q;
    logic [EXC_W-1:0]  exc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            pc_q   <= PC_RST;
            exc_q  <= '0;
        end else if (ld_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
            exc_q  <= exc_i;
        end
    end

    assign data_o = data_q;
    assign pc_o   = pc_q;
    assign exc_o  = exc_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// ----------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry skid buffer between pipeline stages. The head entry drives the
// outputs; the skid entry absorbs one upstream transfer while downstream is
// stalled, so in_ready can be a pure register.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_EMPTY | nothing held, outputs show bubble values
//   ST_ONE   | head valid, skid free
//   ST_TWO   | head and skid valid, upstream stalled
//
// Accepting an entry that carries any exception flag locks the input side
// (in_ready low) until flush; held entries keep draining.
//   clk  clock            rst  asynchronous active-low reset
//   bus  pipe_skid_stage_if.slave (handshake, payload, flush, occupancy)
// ----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int          DATA_W = 104,
    parameter int          EXC_W  = 8,
    parameter logic [31:0] PC_RST = PC_RST_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_skid_stage_if.slave       bus
);

    state_e state_q, state_d;
    logic   lock_q, lock_d;
    logic   in_ready_q, in_ready_d;

    logic   accept, emit, out_valid;
    logic   head_ld, skid_ld, head_from_skid;

    logic [DATA_W-1:0] head_data, skid_data, head_data_in;
    logic [31:0]       head_pc, skid_pc, head_pc_in;
    logic [EXC_W-1:0]  head_exc, skid_exc, head_exc_in;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign emit      = out_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        lock_d         = lock_q;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    head_ld = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !emit) begin
                    state_d = ST_TWO;
                    skid_ld = 1'b1;
                end else if (accept && emit) begin
                    head_ld = 1'b1;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so accept cannot occur
                if (emit) begin
                    state_d        = ST_ONE;
                    head_ld        = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept && (|bus.in_exc)) begin
            lock_d = 1'b1;
        end

        if (bus.flush) begin
            state_d = ST_EMPTY;
            lock_d  = 1'b0;
            head_ld = 1'b0;
            skid_ld = 1'b0;
        end

        // Computed from next state only, so in_ready never sees out_ready or
        // in_valid combinationally.
        in_ready_d = !lock_d && ((state_d == ST_EMPTY) || (state_d == ST_ONE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            lock_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign head_data_in = head_from_skid ? skid_data : bus.in_data;
    assign head_pc_in   = head_from_skid ? skid_pc   : bus.in_pc;
    assign head_exc_in  = head_from_skid ? skid_exc  : bus.in_exc;

    pipe_entry #(
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W),
        .PC_RST (PC_RST)
    ) u_head (
        .clk    (clk),
        .rst_n  (rst),
        .ld_i   (head_ld),
        .data_i (head_data_in),
        .pc_i   (head_pc_in),
        .exc_i  (head_exc_in),
        .data_o (head_data),
        .pc_o   (head_pc),
        .exc_o  (head_exc)
    );

    pipe_entry #(
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W),
        .PC_RST (PC_RST)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst),
        .ld_i   (skid_ld),
        .data_i (bus.in_data),
        .pc_i   (bus.in_pc),
        .exc_i  (bus.in_exc),
        .data_o (skid_data),
        .pc_o   (skid_pc),
        .exc_o  (skid_exc)
    );

    // Head register may hold stale payload after a flush; gating on
    // out_valid keeps the visible outputs at bubble values.
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? head_data : '0;
    assign bus.out_pc      = out_valid ? head_pc   : PC_RST;
    assign bus.out_exc     = out_valid ? head_exc  : '0;
    assign bus.out_exc_any = out_valid & (|head_exc);
    assign bus.occupancy   = occ_of(state_q);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed scenarios followed by randomized valid/ready/flush traffic, checked
// cycle by cycle against a queue-based model of the stage.
// ----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    localparam int          DW        = 104;
    localparam int          EW        = 8;
    localparam logic [31:0] PC_BUBBLE = 32'hbfc00000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_skid_stage_if #(.DATA_W(DW), .EXC_W(EW)) bus ();

    pipe_skid_stage #(
        .DATA_W (DW),
        .EXC_W  (EW),
        .PC_RST (PC_BUBBLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [31:0]   pc;
        logic [EW-1:0] e;
    } ent_t;

    ent_t mq[$];
    bit   m_lock;
    bit   m_ready;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_emit  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [31:0] pc,
                         input logic [EW-1:0] e, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_pc     = pc;
        bus.in_exc    = e;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic model_reset();
        mq.delete();
        m_lock  = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("occupancy", 128'(bus.occupancy), 128'(mq.size()));
        check_eq("out_valid", 128'(bus.out_valid), 128'(mq.size() != 0));
        check_eq("in_ready",  128'(bus.in_ready),  128'(m_ready));
        if (mq.size() != 0) begin
            check_eq("out_data",    128'(bus.out_data),    128'(mq[0].d));
            check_eq("out_pc",      128'(bus.out_pc),      128'(mq[0].pc));
            check_eq("out_exc",     128'(bus.out_exc),     128'(mq[0].e));
            check_eq("out_exc_any", 128'(bus.out_exc_any), 128'(|mq[0].e));
        end else begin
            check_eq("bubble_data",    128'(bus.out_data),    128'(0));
            check_eq("bubble_pc",      128'(bus.out_pc),      128'(PC_BUBBLE));
            check_eq("bubble_exc",     128'(bus.out_exc),     128'(0));
            check_eq("bubble_exc_any", 128'(bus.out_exc_any), 128'(0));
        end
    endtask

    // One clock: the model applies the same handshake the environment sees
    // just before the edge, then the outputs are compared 1 time unit later.
    task automatic tick();
        bit   acc;
        bit   emt;
        bit   fl;
        ent_t e;
        acc  = bus.in_valid && m_ready;
        emt  = (mq.size() != 0) && bus.out_ready;
        fl   = bus.flush;
        e.d  = bus.in_data;
        e.pc = bus.in_pc;
        e.e  = bus.in_exc;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_lock = 1'b0;
        end else begin
            if (emt) begin
                void'(mq.pop_front());
                n_emit++;
            end
            if (acc) begin
                mq.push_back(e);
                if (|e.e) m_lock = 1'b1;
            end
        end
        m_ready = !m_lock && (mq.size() < 2);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [127:0] r;

        // reset state
        rst = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // streaming with downstream always ready: one per cycle, occupancy 1
        drive(1'b1, DW'(5), 32'hbfc00004, '0, 1'b1, 1'b0);
        repeat (6) tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        tick();

        // stall: fill both entries, then drain in order
        drive(1'b1, DW'(32'haaaa), 32'hbfc00010, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(32'hbbbb), 32'hbfc00014, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(32'hcccc), 32'hbfc00018, '0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        // exception lock holds off new entries until flush
        drive(1'b1, DW'(32'h1111), 32'hbfc00020, 8'b0000_0100, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(32'h2222), 32'hbfc00024, '0, 1'b0, 1'b0);
        repeat (3) tick();
        drive(1'b1, DW'(32'h2222), 32'hbfc00024, '0, 1'b1, 1'b0);
        repeat (2) tick();
        drive(1'b1, DW'(32'h2222), 32'hbfc00024, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick();

        // flush with a new entry presented while full
        drive(1'b1, DW'(32'h3333), 32'hbfc00030, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(32'h4444), 32'hbfc00034, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(32'h5555), 32'hbfc00038, '0, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        tick();

        // asynchronous reset while full
        drive(1'b1, DW'(32'h6666), 32'hbfc00040, '0, 1'b0, 1'b0);
        tick();
        drive(1'b1, DW'(32'h7777), 32'hbfc00044, '0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            drive(($urandom % 4) != 0, r[DW-1:0], $urandom,
                  (($urandom % 40) == 0) ? EW'(1 << ($urandom % EW)) : '0,
                  ($urandom % 3) != 0, ($urandom % 60) == 0);
            if ((i % 8) == 0) begin
                // wiggle the handshake inputs mid-cycle; in_ready must hold
                bus.out_ready = ~bus.out_ready;
                bus.in_valid  = ~bus.in_valid;
                #1;
                check_eq("in_ready_comb", 128'(bus.in_ready), 128'(m_ready));
            end
            tick();
        end
        check_eq("random_emits", 128'(n_emit > 2000), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected finish before 2000000");
        $fatal(1);
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 104, width of the generic payload (wdata, waddr, strb, wen, sram addr, bad inst).
REQ-002 Parameter EXC_W, default 8, number of exception flag bits (slot flag included).
REQ-003 Parameter PC_RST, default 32'hbfc00000, PC value driven when no valid entry is present.
REQ-004 Port clk  in  1  sole clock, all state on rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port flush  in  1  discard all held and incoming entries.
REQ-007 Port in_valid  in  1  upstream entry present.
REQ-008 Port in_ready  out  1  stage can accept this cycle; registered output.
REQ-009 Port in_data / in_pc / in_exc  in  DATA_W / 32 / EXC_W  upstream entry payload.
REQ-010 Port out_valid  out  1  head entry present.
REQ-011 Port out_ready  in  1  downstream consumes head this cycle.
REQ-012 Port out_data / out_pc / out_exc  out  DATA_W / 32 / EXC_W  head entry payload.
REQ-013 Port out_exc_any  out  1  OR-reduction of out_exc, gated by out_valid.
REQ-014 Port occupancy  out  2  entries held (0..2).

Function
REQ-015 Accept = in_valid & in_ready; emit = out_valid & out_ready; both evaluated in the same cycle.
REQ-016 Two entries, head (drives outputs) and skid; states EMPTY, ONE, TWO; occupancy encodes the state as 0/1/2.
REQ-017 EMPTY: accept -> ONE, head <= input; otherwise stay.
REQ-018 ONE: accept & !emit -> TWO, skid <= input; accept & emit -> ONE, head <= input; emit only -> EMPTY; neither -> stay.
REQ-019 TWO: emit -> ONE, head <= skid; no accept possible; otherwise stay.
REQ-020 in_ready next cycle = 1 when next state is EMPTY, or ONE with no exception lock; 0 in TWO or when locked.
REQ-021 Latency: entry accepted in cycle N from EMPTY appears with out_valid=1 in cycle N+1.
REQ-022 Ordering strictly FIFO; no entry duplicated or dropped except by flush.
REQ-023 Exception lock: accepting an entry with any in_exc bit set deasserts in_ready from the next cycle until flush; entries already held still drain normally.
REQ-024 Flush has highest priority: next state EMPTY, lock cleared, in_ready=1 next cycle; input presented in the flush cycle is discarded; emit in the flush cycle is still counted as consumed.
REQ-025 When out_valid=0: out_data = 0, out_pc = PC_RST, out_exc = 0, out_exc_any = 0 (bubble values).
REQ-026 No combinational path from out_ready or in_valid to in_ready.

Reset
REQ-027 rst low asynchronously forces state EMPTY, lock clear, head and skid to bubble values.
REQ-028 During reset outputs: in_ready=0, out_valid=0, occupancy=0, out_pc=PC_RST, other payload 0.
REQ-029 First rising edge after rst release sets in_ready=1; reset asserted mid-transfer discards all entries without emitting.

Structure
REQ-030 Shared package pipe_pkg holds the state enumeration (EMPTY/ONE/TWO), PC_RST default constant, and exception bit index constants (syscall, break, reserved, overflow, AdES, AdEL, AdEF, slot).
REQ-031 One sub-module pipe_entry: a single payload register (data, pc, exc) with load enable and asynchronous clear to bubble values, instantiated twice (head, skid).

Verification
REQ-032 Reset release, in_valid=1, in_data=5, in_pc=32'hbfc00004, out_ready=1 every cycle -> out_valid=1, out_data=5, out_pc=32'hbfc00004 one cycle later; throughput one entry per cycle, occupancy stays 1.
REQ-033 out_ready=0, push A,B -> occupancy=2, in_ready=0; then out_ready=1 -> A then B emitted in consecutive cycles, in_ready=1 the cycle after A leaves.
REQ-034 Push entry with in_exc=8'b0000_0100 then valid C -> C not accepted, in_ready=0 until flush; flush -> occupancy=0, out_pc=32'hbfc00000, in_ready=1 next cycle.
REQ-035 Flush asserted together with in_valid in TWO -> both held entries and the incoming entry discarded, out_valid=0 next cycle.
REQ-036 rst driven low between clock edges while occupancy=2 -> out_valid=0, occupancy=0, out_pc=32'hbfc00000 immediately, without waiting for clk.
REQ-037 Random valid/ready stimulus, 10000 cycles -> output sequence equals input sequence exactly (scoreboard), in_ready never combinationally depends on out_ready.
